// File: rtl/sync_down_counter_if.sv
// sync_down_counter_if: control and status bundle for the down-counter/timer
interface sync_down_counter_if #(parameter int WIDTH = 4);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;
  modport master (output load, load_val, en, auto_reload, input count, tc, busy, done);
  modport slave  (input load, load_val, en, auto_reload, output count, tc, busy, done);
endinterface

// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable down-counter with one-shot/periodic terminal count
module sync_down_counter #(parameter int WIDTH = 4) (
  input  logic                 clk,
  input  logic                 rst,
  sync_down_counter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
  logic             tc_q, tc_d;
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = (bus.load_val != '0) ? RUN : DONE;
    end else if (state_q == RUN && bus.en) begin
      if (count_q > WIDTH'(1)) count_d = count_q - WIDTH'(1);
      else if (count_q == WIDTH'(1)) begin
        tc_d    = 1'b1;
        count_d = bus.auto_reload ? reload_q : '0;
        state_d = bus.auto_reload ? RUN : DONE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter: directed plan plus random stimulus against a period-based model
module tb_sync_down_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0, fails = 0, pulses = 0;
  int m_n = 0, m_k = 0, m_st = 0;
  bit m_tc = 0;
  sync_down_counter_if #(.WIDTH(4)) bus();
  sync_down_counter #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_count"}, 32'(bus.count), (m_st == 1) ? 32'(m_n - m_k) : 0);
    chk({tag, "_tc"}, 32'(bus.tc), 32'(m_tc));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(m_st == 1));
    chk({tag, "_done"}, 32'(bus.done), 32'(m_st == 2));
  endtask

  // m_k counts enabled edges within the current period of length m_n
  task automatic step(input string tag, input bit ld, input int lv, input bit e, input bit ar);
    bus.load = ld; bus.load_val = 4'(lv); bus.en = e; bus.auto_reload = ar;
    @(posedge clk);
    m_tc = 0;
    if (ld) begin
      m_n = lv; m_k = 0; m_st = (lv != 0) ? 1 : 2;
    end else if (m_st == 1 && e) begin
      m_k++;
      if (m_k == m_n) begin
        m_tc = 1;
        m_k = 0;
        if (!ar) m_st = 2;
      end
    end
    #1;
    if (bus.tc === 1'b1) pulses++;
    chk_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    m_n = 0; m_k = 0; m_st = 0; m_tc = 0;
    #1 chk_all(tag);
    #1 rst = 1'b1;
  endtask

  initial begin
    bus.load = 0; bus.load_val = '0; bus.en = 0; bus.auto_reload = 0;
    repeat (2) @(posedge clk);
    #1 chk_all("reset");
    rst = 1'b1;
    step("idle_en", 0, 0, 1, 1);
    step("os_load", 1, 3, 0, 0);
    step("os_d1", 0, 0, 1, 0);
    step("os_d2", 0, 0, 1, 0);
    step("os_d3", 0, 0, 1, 0);
    chk("os_tc_const", 32'(bus.tc), 1);
    step("os_hold", 0, 0, 1, 0);
    chk("os_done_const", 32'(bus.done), 1);
    step("per_load", 1, 4, 0, 1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step("per", 0, 0, 1, 1);
      chk("per_busy_const", 32'(bus.busy), 1);
    end
    chk("per_pulses", 32'(pulses), 3);
    step("gate_load", 1, 2, 0, 0);
    step("gate_e1", 0, 0, 1, 0);
    step("gate_e0a", 0, 0, 0, 0);
    step("gate_e0b", 0, 0, 0, 0);
    chk("gate_wait1", 32'(bus.count), 1);
    step("gate_e1b", 0, 0, 1, 0);
    chk("gate_tc_const", 32'(bus.tc), 1);
    step("col_load", 1, 2, 0, 0);
    step("col_d1", 0, 0, 1, 0);
    step("col_hit", 1, 9, 1, 0);
    chk("col_count_const", 32'(bus.count), 9);
    step("zero_load", 1, 0, 1, 1);
    chk("zero_done_const", 32'(bus.done), 1);
    step("max_load", 1, 15, 0, 1);
    pulses = 0;
    for (int i = 0; i < 30; i++) step("max", 0, 0, 1, 1);
    chk("max_pulses", 32'(pulses), 2);
    chk("max_reload", 32'(bus.count), 15);
    step("one_load", 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) step("one_per", 0, 0, 1, 1);
    step("rst_load", 1, 7, 0, 0);
    step("rst_d1", 0, 0, 1, 0);
    step("rst_d2", 0, 0, 1, 0);
    chk("rst_at5", 32'(bus.count), 5);
    async_reset("rst_mid");
    step("rst_after", 0, 0, 1, 1);
    step("rst_after2", 0, 0, 1, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      step("rnd", $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sync_down_counter.md
# sync_down_counter

- Parameterised synchronous down-counter/timer that loads a start value and decrements on each enabled clock.
- Flags the terminal count and either stops there (one-shot) or reloads the start value (periodic).
- Complements the team's ripple up-counters: it counts the other way, updates every bit on a single clock edge, and provides a programmable divider/timeout source for the counter designs.

## Interface
Parameters:
- WIDTH, 4, bit width of count, load_val and the internal reload register

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-low
- load  input  1  load load_val into count and the reload register; highest synchronous priority
- load_val  input  WIDTH  start/reload value, unsigned
- en  input  1  count enable; decrement only when high in RUN
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled on the terminal cycle
- count  output  WIDTH  current counter value
- tc  output  1  registered one-cycle pulse on terminal count
- busy  output  1  high while in RUN
- done  output  1  high while in DONE

## Operation
Reset (rst low, immediate, independent of clk):
- State goes to IDLE; count, reload register, tc, busy and done all go to 0.
- Reset mid-operation aborts the count immediately, with no tc pulse.

States:
- IDLE: count=0. en and auto_reload are ignored. Leaves only on load.
- RUN: counts while en=1; holds count while en=0.
- DONE: count=0, done=1. en is ignored. Leaves only on load.

Rising-edge priority, highest first:
1. load=1, from any state:
   - count and reload register take load_val; tc=0.
   - load_val≠0: next state is RUN.
   - load_val=0: next state is DONE, with no tc pulse.
2. RUN, en=1, count>1: count decrements by 1; tc=0.
3. RUN, en=1, count==1 (terminal): tc=1 for this cycle.
   - auto_reload=1: count takes the reload register; stay in RUN.
   - auto_reload=0: count goes to 0; move to DONE.
4. Otherwise: hold count and state; tc=0.

Arithmetic and flags:
- Unsigned arithmetic; no wrap-around is possible, since count never decrements from 0.
- busy and done are decoded from the state register, so they are glitch-free and change in the same cycle as the state.
- One-shot: tc asserts once per load.
- Periodic: tc asserts once per load_val enabled cycles.

## Timing
- Latency:
  - Load to first decrement: 1 cycle.
  - After a load of N≠0 with en held high, tc is high in the cycle after the Nth enabled edge.
  - busy falls and done rises on that same edge, i.e. count reaches 0 on the Nth edge.
- tc lasts exactly one clk cycle per terminal event, even if en stays high.
- Reload value 1 with auto_reload=1: count stays 1 and tc is high on every enabled cycle.
- load and terminal on the same edge: load wins and tc stays 0.
- en low on the would-be terminal edge: no tc; the count waits at 1.
- auto_reload may change mid-count; only its value on the terminal edge matters.
- load_val is sampled only on edges where load=1; it may change freely at other times.

## Test plan
All scenarios use WIDTH=4.
- Reset: drive rst low mid-RUN at count=5 → count=0, busy=0, done=0, tc=0 before the next clk edge; state is IDLE and a later en=1 leaves count at 0.
- One-shot: load 3, en=1, auto_reload=0 → count runs 3,2,1,0; tc is high for 1 cycle as count hits 0; done=1 afterwards; count stays 0 with en still high.
- Periodic: load 4, auto_reload=1, en=1 for 12 cycles → count runs 4,3,2,1,4,3,2,1,…; tc pulses every 4th cycle (3 pulses); busy stays 1 throughout.
- Enable gating: load 2, en toggles 1,0,0,1 → count runs 2,1,1,1,0; tc is asserted only with the final decrement.
- Collision and zero load:
  - load=1 with load_val=9 on the edge where count==1 and en=1 → count=9, tc=0, state RUN.
  - A separate load of 0 → done=1, busy=0, tc=0.
- Max value: load 15, auto_reload=1, en=1 → 15 decrements between tc pulses; count reloads 15 with no wrap to 0xF via underflow.
